// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7N2 serial receiver: FSM state codes and frame geometry.
package rx_serial_pkg;

   localparam logic [3:0] ST_OCIOSO  = 4'd0;
   localparam logic [3:0] ST_INICIO  = 4'd1;
   localparam logic [3:0] ST_DADOS   = 4'd2;
   localparam logic [3:0] ST_PARADA1 = 4'd3;
   localparam logic [3:0] ST_PARADA2 = 4'd4;
   localparam logic [3:0] ST_FIM     = 4'd5;

   typedef enum logic [3:0] {
      OCIOSO  = ST_OCIOSO,
      INICIO  = ST_INICIO,
      DADOS   = ST_DADOS,
      PARADA1 = ST_PARADA1,
      PARADA2 = ST_PARADA2,
      FIM     = ST_FIM
   } estado_t;

   localparam int DATA_BITS = 7;
   localparam int STOP_BITS = 2;

endpackage

// File: rtl/rx_serial_7n2_fd.sv
// Receiver datapath: input synchroniser, bit timing, bit counter, shift register
// and the character/flag registers presented to the consumer.
module rx_serial_7n2_fd
   import rx_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int CW           = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dados_serial,
   input  logic       recebe_dado,
   input  logic       zera_tempo,
   input  logic       zera_bits,
   input  logic       amostra_dado,
   input  logic       amostra_stop1,
   input  logic       amostra_stop2,
   input  logic       fim,
   output logic       rx_s,
   output logic       tempo_meio,
   output logic       tempo_fim,
   output logic       ultimo_bit,
   output logic [6:0] dados_ascii,
   output logic       pronto,
   output logic       tem_dado,
   output logic       erro_stop,
   output logic       erro_overrun
);

   localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);

   logic                 sync1_reg, sync2_reg;
   logic [CW-1:0]        tempo_reg;
   logic [2:0]           bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 stop_ok1_reg, stop_ok2_reg;
   logic [DATA_BITS-1:0] dados_ascii_reg;
   logic                 pronto_reg, tem_dado_reg, erro_stop_reg, erro_overrun_reg;
   logic                 erro_stop_next;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= dados_serial;
         sync2_reg <= sync1_reg;
      end
   end
   assign rx_s = sync2_reg;

   always_ff @(posedge clock) begin
      if (reset || zera_tempo) tempo_reg <= '0;
      else                     tempo_reg <= tempo_reg + 1'b1;
   end
   assign tempo_meio = (tempo_reg == HALF_TERM);
   assign tempo_fim  = (tempo_reg == FULL_TERM);

   always_ff @(posedge clock) begin
      if (reset || zera_bits) bit_cnt_reg <= '0;
      else if (amostra_dado)  bit_cnt_reg <= bit_cnt_reg + 3'd1;
   end
   assign ultimo_bit = (bit_cnt_reg == 3'(DATA_BITS - 1));

   // LSB arrives first, so each new bit enters at the top and shifts right.
   for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      if (gi == DATA_BITS - 1) begin : g_msb
         assign shift_next[gi] = rx_s;
      end else begin : g_low
         assign shift_next[gi] = shift_reg[gi+1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_reg    <= '0;
         stop_ok1_reg <= 1'b0;
         stop_ok2_reg <= 1'b0;
      end else begin
         if (amostra_dado)  shift_reg    <= shift_next;
         if (amostra_stop1) stop_ok1_reg <= rx_s;
         if (amostra_stop2) stop_ok2_reg <= rx_s;
      end
   end

   assign erro_stop_next = ~(stop_ok1_reg & stop_ok2_reg);

   // Frame completion takes priority over a simultaneous acknowledge.
   always_ff @(posedge clock) begin
      if (reset) begin
         dados_ascii_reg  <= '0;
         pronto_reg       <= 1'b0;
         tem_dado_reg     <= 1'b0;
         erro_stop_reg    <= 1'b0;
         erro_overrun_reg <= 1'b0;
      end else begin
         pronto_reg <= fim;
         if (fim) begin
            dados_ascii_reg  <= shift_reg;
            erro_stop_reg    <= erro_stop_next;
            erro_overrun_reg <= erro_overrun_reg | tem_dado_reg;
            tem_dado_reg     <= erro_stop_next ? (tem_dado_reg & ~recebe_dado) : 1'b1;
         end else if (recebe_dado) begin
            tem_dado_reg     <= 1'b0;
            erro_overrun_reg <= 1'b0;
         end
      end
   end

   assign dados_ascii  = dados_ascii_reg;
   assign pronto       = pronto_reg;
   assign tem_dado     = tem_dado_reg;
   assign erro_stop    = erro_stop_reg;
   assign erro_overrun = erro_overrun_reg;

endmodule

// File: rtl/rx_serial_7n2.sv
// 7N2 asynchronous serial receiver: control FSM driving the rx_serial_7n2_fd datapath.
module rx_serial_7n2
   import rx_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int CW           = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dados_serial,
   input  logic       recebe_dado,
   output logic [6:0] dados_ascii,
   output logic       pronto,
   output logic       tem_dado,
   output logic       erro_stop,
   output logic       erro_overrun,
   output logic [3:0] db_estado
);

   estado_t state_reg, state_next;

   logic rx_s, tempo_meio, tempo_fim, ultimo_bit;
   logic zera_tempo, zera_bits, amostra_dado, amostra_stop1, amostra_stop2, fim;

   rx_serial_7n2_fd #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_fd (
      .clock         (clock),
      .reset         (reset),
      .dados_serial  (dados_serial),
      .recebe_dado   (recebe_dado),
      .zera_tempo    (zera_tempo),
      .zera_bits     (zera_bits),
      .amostra_dado  (amostra_dado),
      .amostra_stop1 (amostra_stop1),
      .amostra_stop2 (amostra_stop2),
      .fim           (fim),
      .rx_s          (rx_s),
      .tempo_meio    (tempo_meio),
      .tempo_fim     (tempo_fim),
      .ultimo_bit    (ultimo_bit),
      .dados_ascii   (dados_ascii),
      .pronto        (pronto),
      .tem_dado      (tem_dado),
      .erro_stop     (erro_stop),
      .erro_overrun  (erro_overrun)
   );

   always_ff @(posedge clock) begin
      if (reset) state_reg <= OCIOSO;
      else       state_reg <= state_next;
   end

   // The timing counter restarts on every state change and every sample.
   always_comb begin
      state_next    = state_reg;
      zera_tempo    = 1'b0;
      zera_bits     = 1'b0;
      amostra_dado  = 1'b0;
      amostra_stop1 = 1'b0;
      amostra_stop2 = 1'b0;
      fim           = 1'b0;
      case (state_reg)
         OCIOSO: begin
            zera_tempo = 1'b1;
            if (!rx_s) state_next = INICIO;
         end
         INICIO: begin
            if (tempo_meio) begin
               zera_tempo = 1'b1;
               if (!rx_s) begin
                  zera_bits  = 1'b1;
                  state_next = DADOS;
               end else begin
                  state_next = OCIOSO;
               end
            end
         end
         DADOS: begin
            if (tempo_fim) begin
               zera_tempo   = 1'b1;
               amostra_dado = 1'b1;
               if (ultimo_bit) state_next = PARADA1;
            end
         end
         PARADA1: begin
            if (tempo_fim) begin
               zera_tempo    = 1'b1;
               amostra_stop1 = 1'b1;
               state_next    = PARADA2;
            end
         end
         PARADA2: begin
            if (tempo_fim) begin
               zera_tempo    = 1'b1;
               amostra_stop2 = 1'b1;
               state_next    = FIM;
            end
         end
         FIM: begin
            zera_tempo = 1'b1;
            fim        = 1'b1;
            state_next = OCIOSO;
         end
         default: begin
            zera_tempo = 1'b1;
            state_next = OCIOSO;
         end
      endcase
   end

   assign db_estado = state_reg;

endmodule

// File: tb/tb_rx_serial_7n2.sv
// Scoreboard bench for rx_serial_7n2: frames push expected results, a monitor checks each pronto.
module tb_rx_serial_7n2;

   localparam int CPB = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       dados_serial;
   logic       recebe_dado;
   logic [6:0] dados_ascii;
   logic       pronto, tem_dado, erro_stop, erro_overrun;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [6:0] data;
      logic       err;
      logic       tem;
      logic       ovr;
      int         start_cyc;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   rx_serial_7n2 #(.CLKS_PER_BIT(CPB), .CW(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .dados_serial (dados_serial),
      .recebe_dado  (recebe_dado),
      .dados_ascii  (dados_ascii),
      .pronto       (pronto),
      .tem_dado     (tem_dado),
      .erro_stop    (erro_stop),
      .erro_overrun (erro_overrun),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      dados_serial = b;
      tick(CPB);
   endtask

   task automatic send_frame(input string name, input logic [6:0] d, input logic stop2,
                             input logic e_err, input logic e_tem, input logic e_ovr);
      exp_t e;
      e.data = d; e.err = e_err; e.tem = e_tem; e.ovr = e_ovr;
      e.start_cyc = cyc; e.name = name;
      exp_q.push_back(e);
      $display("send %s data=%02h stop2=%0b", name, d, stop2);
      drive_bit(1'b0);
      for (int i = 0; i < 7; i++) drive_bit(d[i]);
      drive_bit(1'b1);
      drive_bit(stop2);
      dados_serial = 1'b1;
   endtask

   // Monitor: every pronto must match the oldest outstanding expectation.
   logic pronto_prev = 1'b0;
   always @(negedge clock) begin
      exp_t e;
      int   lat;
      if (!reset && pronto) begin
         chk("pronto_one_cycle", pronto_prev, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pronto", 1, 0);
         end else begin
            e   = exp_q.pop_front();
            lat = cyc - e.start_cyc;
            $display("pronto %s data=%02h erro_stop=%0b tem_dado=%0b erro_overrun=%0b latency=%0d",
                     e.name, dados_ascii, erro_stop, tem_dado, erro_overrun, lat);
            chk({e.name, "_data"}, dados_ascii, e.data);
            chk({e.name, "_erro_stop"}, erro_stop, e.err);
            chk({e.name, "_tem_dado"}, tem_dado, e.tem);
            chk({e.name, "_erro_overrun"}, erro_overrun, e.ovr);
            checks++;
            if (lat < 76 || lat > 92) begin
               errors++;
               $display("FAIL %s_latency actual=%0d required=76..92", e.name, lat);
            end
         end
      end
      pronto_prev = pronto;
   end

   initial begin
      bit saw_inicio;
      reset        = 1'b1;
      dados_serial = 1'b1;
      recebe_dado  = 1'b0;
      tick(3);
      reset = 1'b0;
      #4;
      chk("reset_data", dados_ascii, 0);
      chk("reset_flags", {pronto, tem_dado, erro_stop, erro_overrun}, 0);
      chk("reset_state", db_estado, 0);
      tick(50);
      chk("idle_flags", {pronto, tem_dado, erro_stop, erro_overrun}, 0);
      chk("idle_state", db_estado, 0);

      // Good frame, then acknowledge
      send_frame("A", 7'h41, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(20);
      chk("A_pronto_seen", exp_q.size(), 0);
      recebe_dado = 1'b1;
      tick(1);
      recebe_dado = 1'b0;
      chk("A_ack_tem_dado", tem_dado, 0);
      chk("A_ack_data_kept", dados_ascii, 7'h41);

      // Bad second stop bit
      send_frame("Z_bad_stop", 7'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(20);
      chk("Z_pronto_seen", exp_q.size(), 0);

      // 3-cycle glitch: enters INICIO, returns to OCIOSO, nothing changes
      saw_inicio = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         dados_serial = (i < 3) ? 1'b0 : 1'b1;
         if (db_estado == 4'd1) saw_inicio = 1'b1;
      end
      tick(1);
      $display("glitch saw_inicio=%0b state=%0d", saw_inicio, db_estado);
      chk("glitch_saw_inicio", saw_inicio, 1);
      chk("glitch_state", db_estado, 0);
      chk("glitch_data", dados_ascii, 7'h5A);
      chk("glitch_flags", {tem_dado, erro_stop, erro_overrun}, 3'b010);

      // Back-to-back without acknowledge -> overrun
      send_frame("b2b_31", 7'h31, 1'b1, 1'b0, 1'b1, 1'b0);
      send_frame("b2b_32", 7'h32, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(20);
      chk("b2b_pronto_seen", exp_q.size(), 0);
      recebe_dado = 1'b1;
      tick(1);
      recebe_dado = 1'b0;
      chk("b2b_ack_flags", {tem_dado, erro_overrun}, 0);

      // Reset mid-frame, then a clean 0x00
      $display("abort 7F after 3 data bits");
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      chk("abort_in_dados", db_estado, 2);
      reset        = 1'b1;
      dados_serial = 1'b1;
      tick(2);
      chk("abort_reset_state", db_estado, 0);
      chk("abort_reset_data", dados_ascii, 0);
      reset = 1'b0;
      tick(10);
      send_frame("zero", 7'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(20);
      chk("zero_pronto_seen", exp_q.size(), 0);
      chk("final_state", db_estado, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
